// File: rtl/mem_ctrl.sv
// Memory-side responder: arbitrates instruction-fetch and load/store ports onto a
// byte-serial external RAM bus (read data valid one cycle after its address).
module mem_ctrl #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              inst_re,
  input  logic [31:0]       inst_raddr,
  output logic [31:0]       inst_rdata,
  output logic              inst_busy,
  input  logic              data_re,
  input  logic              data_we,
  input  logic [31:0]       data_addr,
  input  logic [1:0]        data_width,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_busy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {IDLE, IRD, DRD, DWR} state_e;

  state_e              state_q;
  logic [2:0]          cnt_q;
  logic [2:0]          nbytes_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         buf_q;
  logic [ADDR_W-1:0]   iaddr_q;
  logic                ipend_q;
  logic [ADDR_W-1:0]   daddr_q;
  logic [1:0]          dwidth_q;
  logic [31:0]         dwdata_q;
  logic                dwe_q;
  logic                dpend_q;
  logic [31:0]         inst_rdata_q;
  logic [31:0]         data_rdata_q;
  logic                inst_busy_q;
  logic                data_busy_q;
  logic [ADDR_W-1:0]   mem_a_q;
  logic [7:0]          mem_dout_q;
  logic                mem_wr_q;

  logic                inst_acc, data_acc, inst_req, data_req;
  logic                start_data, start_inst;
  logic [ADDR_W-1:0]   sel_daddr, sel_iaddr, issue_addr;
  logic [1:0]          sel_dwidth, cap_idx;
  logic [31:0]         sel_dwdata, rd_word;
  logic                sel_dwe;
  logic [7:0]          wr_byte;

  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_comb begin
    inst_acc   = inst_re & ~inst_busy_q;
    data_acc   = (data_re | data_we) & ~data_busy_q;
    data_req   = dpend_q | data_acc;
    inst_req   = ipend_q | inst_acc;
    start_data = (state_q == IDLE) && data_req;
    start_inst = (state_q == IDLE) && !data_req && inst_req;
    // A pending request was latched earlier; otherwise serve the live strobe.
    sel_daddr  = dpend_q ? daddr_q  : data_addr[ADDR_W-1:0];
    sel_dwidth = dpend_q ? dwidth_q : data_width;
    sel_dwdata = dpend_q ? dwdata_q : data_wdata;
    sel_dwe    = dpend_q ? dwe_q    : data_we;
    sel_iaddr  = ipend_q ? iaddr_q  : inst_raddr[ADDR_W-1:0];
    issue_addr = addr_q + ADDR_W'(cnt_q);
    cap_idx    = 2'(cnt_q - 3'd2);
    wr_byte    = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    rd_word    = buf_q;
    rd_word[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      nbytes_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      buf_q        <= '0;
      iaddr_q      <= '0;
      ipend_q      <= 1'b0;
      daddr_q      <= '0;
      dwidth_q     <= '0;
      dwdata_q     <= '0;
      dwe_q        <= 1'b0;
      dpend_q      <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_busy_q  <= 1'b0;
      data_busy_q  <= 1'b0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
    end else if (rdy) begin
      if (data_acc) begin
        data_busy_q <= 1'b1;
        if (!start_data) begin
          dpend_q  <= 1'b1;
          daddr_q  <= data_addr[ADDR_W-1:0];
          dwidth_q <= data_width;
          dwdata_q <= data_wdata;
          dwe_q    <= data_we;
        end
      end
      if (inst_acc) begin
        inst_busy_q <= 1'b1;
        if (!start_inst) begin
          ipend_q <= 1'b1;
          iaddr_q <= inst_raddr[ADDR_W-1:0];
        end
      end

      case (state_q)
        IDLE: begin
          if (start_data) begin
            dpend_q  <= 1'b0;
            addr_q   <= sel_daddr;
            mem_a_q  <= sel_daddr;
            nbytes_q <= width_bytes(sel_dwidth);
            cnt_q    <= 3'd1;
            buf_q    <= '0;
            if (sel_dwe) begin
              state_q    <= DWR;
              wdata_q    <= sel_dwdata;
              mem_dout_q <= sel_dwdata[7:0];
              mem_wr_q   <= 1'b1;
            end else begin
              state_q <= DRD;
            end
          end else if (start_inst) begin
            ipend_q  <= 1'b0;
            addr_q   <= sel_iaddr;
            mem_a_q  <= sel_iaddr;
            nbytes_q <= 3'd4;
            cnt_q    <= 3'd1;
            buf_q    <= '0;
            state_q  <= IRD;
          end
        end
        IRD, DRD: begin
          // cnt_q = k at edge E(k): issue byte k, capture byte k-2.
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q < nbytes_q) mem_a_q <= issue_addr;
          if (cnt_q >= 3'd2) buf_q[{cap_idx, 3'b000} +: 8] <= mem_din;
          if (cnt_q == nbytes_q + 3'd1) begin
            state_q <= IDLE;
            if (state_q == IRD) begin
              inst_rdata_q <= rd_word;
              inst_busy_q  <= 1'b0;
            end else begin
              data_rdata_q <= rd_word;
              data_busy_q  <= 1'b0;
            end
          end
        end
        DWR: begin
          if (cnt_q < nbytes_q) begin
            mem_a_q    <= issue_addr;
            mem_dout_q <= wr_byte;
            mem_wr_q   <= 1'b1;
            cnt_q      <= cnt_q + 3'd1;
          end else begin
            mem_wr_q    <= 1'b0;
            data_busy_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst_rdata = inst_rdata_q;
  assign inst_busy  = inst_busy_q;
  assign data_rdata = data_rdata_q;
  assign data_busy  = data_busy_q;
  assign mem_dout   = mem_dout_q;
  assign mem_a      = mem_a_q;
  assign mem_wr     = mem_wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model (frozen with rdy) and
// hand-computed expectations checked by immediate assertions.
module tb_mem_ctrl;
  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst, rdy;
  logic          inst_re;
  logic [31:0]   inst_raddr, inst_rdata;
  logic          inst_busy;
  logic          data_re, data_we;
  logic [31:0]   data_addr, data_wdata, data_rdata;
  logic [1:0]    data_width;
  logic          data_busy;
  logic [7:0]    mem_din, mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;

  logic [7:0]    ram [0:(1<<AW)-1];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .inst_re(inst_re), .inst_raddr(inst_raddr), .inst_rdata(inst_rdata), .inst_busy(inst_busy),
    .data_re(data_re), .data_we(data_we), .data_addr(data_addr), .data_width(data_width),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_busy(data_busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram[mem_a];
      if (mem_wr) ram[mem_a] <= mem_dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    ram[17'h10] = 8'h13; ram[17'h11] = 8'h05; ram[17'h12] = 8'h10; ram[17'h13] = 8'h00;
    ram[17'h1FFFF] = 8'hA5; ram[17'h0] = 8'h11; ram[17'h1] = 8'h22; ram[17'h2] = 8'h33;
    ram[17'h102] = 8'h77; ram[17'h103] = 8'h66;
    mem_din = 8'h00;
    rst = 1'b1; rdy = 1'b1;
    inst_re = 1'b0; inst_raddr = '0;
    data_re = 1'b0; data_we = 1'b0; data_addr = '0; data_width = '0; data_wdata = '0;
    step(); step();
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    chk("rst_busy", {30'h0, inst_busy, data_busy}, 32'h0);
    chk("rst_mem", {7'h0, mem_wr, mem_dout, mem_a}, 32'h0);
    rst = 1'b0;
    step();

    // 1: fetch at 0x10, 5 busy cycles
    inst_re = 1'b1; inst_raddr = 32'h0000_0010;
    step();
    inst_re = 1'b0;
    chk("f1_mem_a0", 32'(mem_a), 32'h10);
    cyc = 0;
    while (inst_busy && cyc < 20) begin cyc++; step(); end
    chk("f1_busy_cycles", cyc, 5);
    chk("f1_rdata", inst_rdata, 32'h0010_0513);

    // 2: load byte at top of RAM, then word load wrapping to 0
    data_re = 1'b1; data_width = 2'b00; data_addr = 32'h0001_FFFF;
    step();
    data_re = 1'b0;
    chk("lb_mem_a", 32'(mem_a), 32'h1FFFF);
    cyc = 0;
    while (data_busy && cyc < 20) begin cyc++; step(); end
    chk("lb_busy_cycles", cyc, 2);
    chk("lb_rdata", data_rdata, 32'h0000_00A5);

    data_re = 1'b1; data_width = 2'b10; data_addr = 32'hABC1_FFFF;
    step();
    data_re = 1'b0;
    chk("lw_mem_a0", 32'(mem_a), 32'h1FFFF); step();
    chk("lw_mem_a1", 32'(mem_a), 32'h00000); step();
    chk("lw_mem_a2", 32'(mem_a), 32'h00001); step();
    chk("lw_mem_a3", 32'(mem_a), 32'h00002);
    cyc = 0;
    while (data_busy && cyc < 20) begin cyc++; step(); end
    chk("lw_rdata", data_rdata, 32'h3322_11A5);

    // 3: store half then word load
    data_we = 1'b1; data_re = 1'b1; data_width = 2'b01; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
    step();
    data_we = 1'b0; data_re = 1'b0;
    chk("sh_b0", {mem_wr, mem_dout, 15'h0, mem_a}, {1'b1, 8'hEF, 15'h0, 17'h100});
    step();
    chk("sh_b1", {mem_wr, mem_dout, 15'h0, mem_a}, {1'b1, 8'hBE, 15'h0, 17'h101});
    chk("sh_busy_b1", 32'(data_busy), 32'h1);
    step();
    chk("sh_done", {30'h0, mem_wr, data_busy}, 32'h0);
    data_re = 1'b1; data_width = 2'b11; data_addr = 32'h100;
    step();
    data_re = 1'b0;
    cyc = 0;
    while (data_busy && cyc < 20) begin cyc++; step(); end
    chk("sh_readback", data_rdata, 32'h6677_BEEF);

    // 4: simultaneous fetch and load half, data first
    inst_re = 1'b1; inst_raddr = 32'h0001_FFFF;
    data_re = 1'b1; data_width = 2'b01; data_addr = 32'h0;
    step();
    inst_re = 1'b0; data_re = 1'b0;
    chk("arb_both_busy", {30'h0, inst_busy, data_busy}, 32'h3);
    chk("arb_data_first", 32'(mem_a), 32'h0);
    step(); step(); step();
    chk("arb_data_done", {30'h0, inst_busy, data_busy}, 32'h2);
    chk("arb_data_rdata", data_rdata, 32'h0000_2211);
    step();
    chk("arb_fetch_start", 32'(mem_a), 32'h1FFFF);
    cyc = 0;
    while (inst_busy && cyc < 20) begin cyc++; step(); end
    chk("arb_fetch_cycles", cyc, 5);
    chk("arb_fetch_rdata", inst_rdata, 32'h3322_11A5);

    // 5: rdy low 3 cycles mid-fetch
    inst_re = 1'b1; inst_raddr = 32'h10;
    step();
    inst_re = 1'b0;
    cyc = 0;
    while (inst_busy && cyc < 40) begin
      cyc++;
      if (cyc == 2) rdy = 1'b0;
      if (cyc >= 3 && cyc <= 5) begin
        chk("frz_mem_a", 32'(mem_a), 32'h11);
        chk("frz_mem_wr", 32'(mem_wr), 32'h0);
      end
      if (cyc == 5) rdy = 1'b1;
      step();
    end
    chk("frz_busy_cycles", cyc, 8);
    chk("frz_rdata", inst_rdata, 32'h0010_0513);

    // rdy low during a store byte: write enable masked, write completes later
    data_we = 1'b1; data_width = 2'b00; data_addr = 32'h200; data_wdata = 32'h0000_005C;
    step();
    data_we = 1'b0;
    chk("sfrz_wr_on", 32'(mem_wr), 32'h1);
    rdy = 1'b0; #1;
    chk("sfrz_wr_masked", 32'(mem_wr), 32'h0);
    step();
    chk("sfrz_hold", {30'h0, mem_wr, data_busy}, 32'h1);
    rdy = 1'b1; #1;
    chk("sfrz_resume", {mem_wr, 14'h0, mem_a}, {1'b1, 14'h0, 17'h200});
    step();
    chk("sfrz_done", {30'h0, mem_wr, data_busy}, 32'h0);
    chk("sfrz_ram", 32'(ram[17'h200]), 32'h5C);

    // 6: reset during byte 1 of a word store
    data_we = 1'b1; data_width = 2'b10; data_addr = 32'h300; data_wdata = 32'h0102_0304;
    step();
    data_we = 1'b0;
    step();
    chk("rstst_b1", {mem_wr, mem_dout, 15'h0, mem_a}, {1'b1, 8'h03, 15'h0, 17'h301});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstst_cleared", {5'h0, data_busy, mem_wr, mem_dout, mem_a}, 32'h0);
    chk("rstst_rdata", data_rdata, 32'h0);
    step(); step();
    chk("rstst_no_wr", 32'(mem_wr), 32'h0);
    chk("rstst_ram", {ram[17'h300], ram[17'h301], ram[17'h302], ram[17'h303]}, 32'h0403_0000);
    inst_re = 1'b1; inst_raddr = 32'h10;
    step();
    inst_re = 1'b0;
    cyc = 0;
    while (inst_busy && cyc < 20) begin cyc++; step(); end
    chk("rstst_fetch_cycles", cyc, 5);
    chk("rstst_fetch_rdata", inst_rdata, 32'h0010_0513);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
